slow2fast_evt: RTL and testbench
================================

# slow2fast_evt

Fast-domain event extractor sitting directly downstream of the slow→fast level synchronizer. It takes the already-synchronized level in the `clk2` domain and glitch-filters it. It then produces single-cycle rise/fall pulses, a saturating rise counter, and a one-entry event record offered on a valid/ready handshake to the consumer logic.

## Interface

Parameters:
- `FILT_LEN`, default 4: consecutive cycles a new level must be held before acceptance; legal range 1..255.
- `CNT_W`, default 8: width of the rise-event counter.

Ports:
- `clk2`, input, 1: fast-domain clock. Single clock; all logic on its rising edge.
- `rstn`, input, 1: asynchronous active-low reset.
- `sig_in`, input, 1: synchronized level from the synchronizer output (`sig2`).
- `cnt_clr`, input, 1: synchronous clear of `evt_cnt` and `evt_ovf`.
- `level_q`, output, 1: filtered level.
- `rise_pls`, output, 1: one-cycle pulse on an accepted 0→1 transition.
- `fall_pls`, output, 1: one-cycle pulse on an accepted 1→0 transition.
- `evt_cnt`, output, CNT_W: count of accepted rises, saturating.
- `evt_valid`, output, 1: event record pending.
- `evt_type`, output, 1: type of the pending record; 1 = rise, 0 = fall.
- `evt_ready`, input, 1: consumer accepts the record.
- `evt_ovf`, output, 1: sticky flag set when an event was dropped.

## Operation

- All outputs reset to 0. The FSM resets to LOW, with the filter counter at 0.
- FSM states:
  - LOW: stable low. `sig_in`=1 → RISE with cnt=1.
  - RISE: `sig_in`=0 → LOW with cnt=0, no pulse. `sig_in`=1 and cnt=FILT_LEN-1 → HIGH. Otherwise cnt+1.
  - HIGH and FALL mirror LOW and RISE with polarity inverted.
- FILT_LEN=1: any transition LOW→HIGH or HIGH→LOW completes on the first sampled edge. RISE/FALL are never occupied.
- Filter counter width is 8 bits. It never exceeds FILT_LEN-1.
- On the edge entering HIGH from RISE:
  - `level_q`←1.
  - `rise_pls`=1 for exactly that cycle.
  - The event record is loaded with type 1.
- On the edge entering LOW from FALL, the same happens with `fall_pls` and type 0.
- `evt_cnt` increments on each `rise_pls` and saturates at 2^CNT_W-1 (no wrap).
- `cnt_clr` and `rise_pls` in the same cycle → `evt_cnt`=1.
- Handshake:
  - Transfer occurs when `evt_valid`&`evt_ready` at a rising edge.
  - `evt_type` is stable while `evt_valid`=1.
  - New event on the same edge as a transfer: the new record is loaded and `evt_valid` stays 1.
  - New event while `evt_valid`=1 and `evt_ready`=0: the new event is dropped, the pending record is kept, and `evt_ovf`←1. Pulses and the counter still update.
- `evt_ovf` clears only on `cnt_clr` or reset. If `cnt_clr` and an overflow occur together, `evt_ovf` ends 1.
- `sig_in` already high when reset deasserts: treated as a rise and reported after FILT_LEN cycles.
- Reset mid-filter or mid-handshake: abort immediately to reset values. Any pending record is lost.

## Timing

- Latency from the first edge sampling a new stable `sig_in` level to `level_q`/pulse/`evt_valid`: FILT_LEN-1 further edges. Outputs change on the FILT_LEN-th sampling edge.
- All outputs are registered; there is no combinational path from `sig_in` or `evt_ready` to any output.
- Minimum spacing between opposite pulses is FILT_LEN cycles.
- Throughput is one record per cycle when `evt_ready` is held high.

## Configuration

- `SLOW2FAST_EVT_FILT_EN` defined: glitch filter as described, using FILT_LEN.
- `SLOW2FAST_EVT_FILT_EN` undefined:
  - RISE/FALL states and the filter counter are not built, and FILT_LEN is ignored.
  - Behaviour is identical to FILT_LEN=1: `level_q` follows `sig_in` one edge later, and any `sig_in` change produces a pulse.

## Test plan

- Reset, then `sig_in`=1 held, FILT_LEN=4 → on the 4th sampling edge `level_q`=1, `rise_pls`=1 for one cycle, `evt_valid`=1, `evt_type`=1, `evt_cnt`=1.
- With `level_q`=1, a 3-cycle low glitch on `sig_in` at FILT_LEN=4 → no `fall_pls`, `level_q` stays 1, `evt_cnt` unchanged. A 4-cycle low → `fall_pls`, record type 0.
- `evt_ready`=0 with a rise record pending, then a fall accepted → `evt_ovf`=1, pending `evt_type` still 1. Raise `evt_ready` → one transfer, `evt_valid`=0.
- CNT_W=2, 5 accepted rises with `evt_ready`=1 → `evt_cnt` = 1,2,3,3,3. `cnt_clr` coincident with the 6th rise → `evt_cnt`=1 and `evt_ovf`=0.
- Transfer and new event on the same edge → `evt_valid` remains 1 with the new `evt_type`, and `evt_ovf` stays 0.
- Assert `rstn`=0 while in RISE with a record pending → all outputs 0 immediately (asynchronously). After release with `sig_in`=0 there are no pulses.

Source files
------------

// File: rtl/slow2fast_evt.sv
// slow2fast_evt: turns the synchronized slow-domain level into filtered level, edge pulses,
// a saturating rise count and a one-deep event record. Filter built only with SLOW2FAST_EVT_FILT_EN.
module slow2fast_evt #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk2,
  input  logic             rstn,
  input  logic             sig_in,
  input  logic             cnt_clr,
  output logic             level_q,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             evt_valid,
  output logic             evt_type,
  input  logic             evt_ready,
  output logic             evt_ovf
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic rise_d;
  logic fall_d;
  logic evt_new;
  logic evt_take;
  logic evt_drop;

`ifdef SLOW2FAST_EVT_FILT_EN
  localparam logic [7:0] FiltLast = 8'(FILT_LEN - 1);

  typedef enum logic [1:0] {StLow, StRise, StHigh, StFall} state_e;

  state_e     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        if (sig_in) begin
          // With FiltLast == 0 the transition completes on the first sampling edge.
          if (FiltLast == 8'd0) begin
            state_d = StHigh;
            rise_d  = 1'b1;
          end else begin
            state_d = StRise;
            fcnt_d  = 8'd1;
          end
        end
      end
      StRise: begin
        if (!sig_in) begin
          state_d = StLow;
          fcnt_d  = 8'd0;
        end else if (fcnt_q == FiltLast) begin
          state_d = StHigh;
          fcnt_d  = 8'd0;
          rise_d  = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      StHigh: begin
        if (!sig_in) begin
          if (FiltLast == 8'd0) begin
            state_d = StLow;
            fall_d  = 1'b1;
          end else begin
            state_d = StFall;
            fcnt_d  = 8'd1;
          end
        end
      end
      StFall: begin
        if (sig_in) begin
          state_d = StHigh;
          fcnt_d  = 8'd0;
        end else if (fcnt_q == FiltLast) begin
          state_d = StLow;
          fcnt_d  = 8'd0;
          fall_d  = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StLow;
        fcnt_d  = 8'd0;
      end
    endcase
  end
`else
  // Unfiltered: every change of the sampled level is an event.
  assign rise_d = sig_in & ~level_q;
  assign fall_d = ~sig_in & level_q;

  logic unused_filt_len;
  assign unused_filt_len = |FILT_LEN;
`endif

  assign evt_new  = rise_d | fall_d;
  assign evt_take = evt_new & (~evt_valid | evt_ready);
  assign evt_drop = evt_new & evt_valid & ~evt_ready;

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
`ifdef SLOW2FAST_EVT_FILT_EN
      state_q <= StLow;
      fcnt_q  <= 8'd0;
`endif
      level_q   <= 1'b0;
      rise_pls  <= 1'b0;
      fall_pls  <= 1'b0;
      evt_cnt   <= '0;
      evt_valid <= 1'b0;
      evt_type  <= 1'b0;
      evt_ovf   <= 1'b0;
    end else begin
`ifdef SLOW2FAST_EVT_FILT_EN
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
`endif
      rise_pls <= rise_d;
      fall_pls <= fall_d;
      if (rise_d) begin
        level_q <= 1'b1;
      end else if (fall_d) begin
        level_q <= 1'b0;
      end

      if (cnt_clr) begin
        evt_cnt <= CNT_W'(rise_d);
      end else if (rise_d && (evt_cnt != CntMax)) begin
        evt_cnt <= evt_cnt + CNT_W'(1);
      end

      if (evt_take) begin
        evt_valid <= 1'b1;
        evt_type  <= rise_d;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end

      // A drop wins over a simultaneous clear so the loss is never hidden.
      if (evt_drop) begin
        evt_ovf <= 1'b1;
      end else if (cnt_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slow2fast_evt.sv
// Directed self-checking bench for slow2fast_evt (FILT_LEN=4, CNT_W=2).
module tb_slow2fast_evt;

`ifdef SLOW2FAST_EVT_FILT_EN
  localparam int F = 4;
`else
  localparam int F = 1;
`endif

  logic       clk2 = 1'b0;
  logic       rstn;
  logic       sig_in;
  logic       cnt_clr;
  logic       level_q;
  logic       rise_pls;
  logic       fall_pls;
  logic [1:0] evt_cnt;
  logic       evt_valid;
  logic       evt_type;
  logic       evt_ready;
  logic       evt_ovf;

  int n_checks = 0;
  int n_errors = 0;

  slow2fast_evt #(
    .FILT_LEN(4),
    .CNT_W   (2)
  ) dut (
    .clk2     (clk2),
    .rstn     (rstn),
    .sig_in   (sig_in),
    .cnt_clr  (cnt_clr),
    .level_q  (level_q),
    .rise_pls (rise_pls),
    .fall_pls (fall_pls),
    .evt_cnt  (evt_cnt),
    .evt_valid(evt_valid),
    .evt_type (evt_type),
    .evt_ready(evt_ready),
    .evt_ovf  (evt_ovf)
  );

  always #5 clk2 = ~clk2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(negedge clk2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".level"}, level_q, 0);
    chk({tag, ".rise"}, rise_pls, 0);
    chk({tag, ".fall"}, fall_pls, 0);
    chk({tag, ".cnt"}, evt_cnt, 0);
    chk({tag, ".valid"}, evt_valid, 0);
    chk({tag, ".type"}, evt_type, 0);
    chk({tag, ".ovf"}, evt_ovf, 0);
  endtask

  // Accepted rise then accepted fall with evt_ready high.
  task automatic rise_fall(input logic [1:0] exp_cnt);
    sig_in = 1'b1;
    for (int i = 0; i < F; i++) step();
    chk("pair.rise", rise_pls, 1);
    chk("pair.cnt", evt_cnt, exp_cnt);
    chk("pair.valid", evt_valid, 1);
    chk("pair.type", evt_type, 1);
    chk("pair.ovf_sticky", evt_ovf, 1);
    sig_in = 1'b0;
    for (int i = 0; i < F; i++) step();
    chk("pair.fall", fall_pls, 1);
    chk("pair.level", level_q, 0);
  endtask

  initial begin
    rstn      = 1'b0;
    sig_in    = 1'b0;
    cnt_clr   = 1'b0;
    evt_ready = 1'b0;
    step();
    step();
    chk_all_zero("reset");

    // First accepted rise, record left pending.
    rstn   = 1'b1;
    sig_in = 1'b1;
    for (int i = 1; i < F; i++) begin
      step();
      chk("rise1.early_level", level_q, 0);
      chk("rise1.early_pulse", rise_pls, 0);
    end
    step();
    chk("rise1.level", level_q, 1);
    chk("rise1.pulse", rise_pls, 1);
    chk("rise1.valid", evt_valid, 1);
    chk("rise1.type", evt_type, 1);
    chk("rise1.cnt", evt_cnt, 1);
    step();
    chk("rise1.pulse_one_cycle", rise_pls, 0);

`ifdef SLOW2FAST_EVT_FILT_EN
    // Low glitch one cycle shorter than the filter.
    sig_in = 1'b0;
    for (int i = 1; i < F; i++) begin
      step();
      chk("glitch.no_fall", fall_pls, 0);
      chk("glitch.level", level_q, 1);
    end
    sig_in = 1'b1;
    step();
    chk("glitch.no_fall_end", fall_pls, 0);
    chk("glitch.no_rise_end", rise_pls, 0);
    chk("glitch.level_end", level_q, 1);
    chk("glitch.cnt", evt_cnt, 1);
`endif

    // Accepted fall while the rise record is still pending: dropped.
    sig_in = 1'b0;
    for (int i = 0; i < F; i++) step();
    chk("drop.fall", fall_pls, 1);
    chk("drop.level", level_q, 0);
    chk("drop.valid", evt_valid, 1);
    chk("drop.type_kept", evt_type, 1);
    chk("drop.ovf", evt_ovf, 1);
    chk("drop.cnt", evt_cnt, 1);

    evt_ready = 1'b1;
    step();
    chk("xfer.valid", evt_valid, 0);
    chk("xfer.fall_one_cycle", fall_pls, 0);

    // Rises 2..5: count saturates at 3.
    rise_fall(2'd2);
    rise_fall(2'd3);
    rise_fall(2'd3);
    rise_fall(2'd3);

    // Sixth rise with coincident clear.
    sig_in = 1'b1;
    for (int i = 1; i < F; i++) step();
    cnt_clr = 1'b1;
    step();
    chk("clr.rise", rise_pls, 1);
    chk("clr.cnt", evt_cnt, 1);
    chk("clr.ovf", evt_ovf, 0);
    chk("clr.valid", evt_valid, 1);
    cnt_clr   = 1'b0;
    evt_ready = 1'b0;

    // Fall arrives on the same edge the pending rise record transfers.
    sig_in = 1'b0;
    for (int i = 1; i < F; i++) begin
      step();
      chk("same_edge.hold_valid", evt_valid, 1);
    end
    evt_ready = 1'b1;
    step();
    chk("same_edge.fall", fall_pls, 1);
    chk("same_edge.valid", evt_valid, 1);
    chk("same_edge.type", evt_type, 0);
    chk("same_edge.ovf", evt_ovf, 0);
    chk("same_edge.cnt", evt_cnt, 1);
    evt_ready = 1'b0;

    // Asynchronous reset with a record pending and a new level in progress.
    sig_in = 1'b1;
    step();
    #2 rstn = 1'b0;
    #1 chk_all_zero("async_rst");
    sig_in = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 2 * F + 2; i++) begin
      step();
      chk("post_rst.rise", rise_pls, 0);
      chk("post_rst.fall", fall_pls, 0);
      chk("post_rst.valid", evt_valid, 0);
    end

    // Level already high when reset releases.
    rstn   = 1'b0;
    sig_in = 1'b1;
    step();
    rstn = 1'b1;
    for (int i = 1; i < F; i++) step();
    chk("powerup.early_level", level_q, 0);
    step();
    chk("powerup.rise", rise_pls, 1);
    chk("powerup.level", level_q, 1);
    chk("powerup.cnt", evt_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
